if_layer_scheduler: RTL and testbench

Time-multiplexed controller for a layer of integrate-and-fire neurons sharing one accumulator and one external weight memory. On each `start` (one SNN timestep) it latches the input spike vector and walks every neuron. For each neuron it issues weight reads for all inputs and accumulates the weights of active inputs into that neuron's stored membrane potential. It then compares the result against the threshold, fires and resets as needed, and reports the layer's output spike vector with a one-cycle `done` pulse.

---
 rtl/snn_pkg.sv | 22 ++
 rtl/if_potential_bank.sv | 31 +++
 rtl/if_layer_scheduler.sv | 158 +++++++++++++++
 tb/tb_if_layer_scheduler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared types and saturating arithmetic for the IF layer scheduler
package snn_pkg;

   localparam int POT_W = 32;

   typedef logic signed [POT_W-1:0] potential_t;

   typedef enum logic [1:0] {IDLE, SCAN, EVAL, DONE} sched_state_t;

   localparam potential_t POT_MAX = {1'b0, {(POT_W-1){1'b1}}};
   localparam potential_t POT_MIN = {1'b1, {(POT_W-1){1'b0}}};

   // Overflow only happens when both operands share a sign that the sum lost.
   function automatic potential_t sat_add(potential_t a, potential_t b);
      potential_t s;
      s = a + b;
      if ((a[POT_W-1] == b[POT_W-1]) && (s[POT_W-1] != a[POT_W-1]))
         s = a[POT_W-1] ? POT_MIN : POT_MAX;
      return s;
   endfunction

endpackage

// File: rtl/if_potential_bank.sv
// rtl/if_potential_bank.sv - membrane potential register file, async read, sync write and clear-all
module if_potential_bank
   import snn_pkg::*;
#(
   parameter int NUM_NEURONS     = 8,
   parameter int RESET_POTENTIAL = 0,
   parameter int ADDR_W          = 3
) (
   input  logic              clk,
   input  logic              clear_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [POT_W-1:0]  wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [POT_W-1:0]  rdata_o
);

   potential_t mem_q [NUM_NEURONS];

   always_ff @(posedge clk) begin
      if (clear_i) begin
         for (int k = 0; k < NUM_NEURONS; k++)
            mem_q[k] <= potential_t'(RESET_POTENTIAL);
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_layer_scheduler.sv
// rtl/if_layer_scheduler.sv - time-multiplexed integrate-and-fire layer controller
// Optional leak before threshold compare is enabled by defining IF_LEAK_EN.
module if_layer_scheduler
   import snn_pkg::*;
#(
   parameter int NUM_INPUTS          = 4,
   parameter int NUM_NEURONS         = 8,
   parameter int WEIGHT_SIZE         = POT_W,
   parameter int THRESHOLD_POTENTIAL = 10,
   parameter int RESET_POTENTIAL     = 0,
   localparam int NN_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
   localparam int NI_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
`ifdef IF_LEAK_EN
   ,
   parameter int LEAK                = 1
`endif
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   clear,
   input  logic [NUM_INPUTS-1:0]  spike_in,
   output logic                   w_rd_en,
   output logic [NN_W-1:0]        w_neuron,
   output logic [NI_W-1:0]        w_input,
   input  logic [WEIGHT_SIZE-1:0] w_data,
   output logic                   busy,
   output logic                   done,
   output logic [NUM_NEURONS-1:0] spike_out
);

   localparam logic [NI_W-1:0] LAST_I  = NI_W'(NUM_INPUTS - 1);
   localparam logic [NN_W-1:0] LAST_N  = NN_W'(NUM_NEURONS - 1);
   localparam potential_t      THRESH  = potential_t'(THRESHOLD_POTENTIAL);
   localparam potential_t      RST_POT = potential_t'(RESET_POTENTIAL);

   sched_state_t           state_q, state_d;
   logic [NN_W-1:0]        n_q, n_d;
   logic [NI_W-1:0]        i_q, i_d;
   logic [NUM_INPUTS-1:0]  spk_q, spk_d;
   logic [NUM_NEURONS-1:0] next_spk_q, next_spk_d;
   logic [NUM_NEURONS-1:0] spike_out_q, spike_out_d;
   potential_t             acc_q, acc_d;

   potential_t      weight, acc_sum, acc_eval, bank_wdata;
   logic [POT_W-1:0] bank_rdata;
   logic [NI_W-1:0] prev_i;
   logic            bank_clear, bank_we, fire;

   if_potential_bank #(
      .NUM_NEURONS     (NUM_NEURONS),
      .RESET_POTENTIAL (RESET_POTENTIAL),
      .ADDR_W          (NN_W)
   ) u_bank (
      .clk     (clk),
      .clear_i (bank_clear),
      .we_i    (bank_we),
      .waddr_i (n_q),
      .wdata_i (bank_wdata),
      .raddr_i (n_q),
      .rdata_o (bank_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         n_q         <= '0;
         i_q         <= '0;
         spk_q       <= '0;
         next_spk_q  <= '0;
         spike_out_q <= '0;
         acc_q       <= RST_POT;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         i_q         <= i_d;
         spk_q       <= spk_d;
         next_spk_q  <= next_spk_d;
         spike_out_q <= spike_out_d;
         acc_q       <= acc_d;
      end
   end

   // Weights return one cycle after their read, so the input being summed is the previous index.
   assign prev_i  = (state_q == EVAL) ? LAST_I : i_q - 1'b1;
   assign weight  = spk_q[prev_i] ? potential_t'(w_data) : '0;
   assign acc_sum = sat_add(acc_q, weight);

   always_comb begin
`ifdef IF_LEAK_EN
      acc_eval = sat_add(acc_sum, -potential_t'(LEAK));
      if (acc_eval < RST_POT)
         acc_eval = RST_POT;
`else
      acc_eval = acc_sum;
`endif
   end

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      i_d         = i_q;
      spk_d       = spk_q;
      next_spk_d  = next_spk_q;
      spike_out_d = spike_out_q;
      acc_d       = acc_q;
      bank_clear  = rst;
      bank_we     = 1'b0;
      fire        = (acc_eval >= THRESH);
      bank_wdata  = fire ? RST_POT : acc_eval;
      w_rd_en     = 1'b0;

      case (state_q)
         IDLE: begin
            if (clear)
               bank_clear = 1'b1;
            if (start) begin
               spk_d   = spike_in;
               n_d     = '0;
               i_d     = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            w_rd_en = 1'b1;
            acc_d   = (i_q == '0) ? potential_t'(bank_rdata) : acc_sum;
            if (i_q == LAST_I) begin
               i_d     = '0;
               state_d = EVAL;
            end else begin
               i_d = i_q + 1'b1;
            end
         end
         EVAL: begin
            bank_we         = 1'b1;
            next_spk_d[n_q] = fire;
            if (n_q == LAST_N) begin
               state_d = DONE;
            end else begin
               n_d     = n_q + 1'b1;
               state_d = SCAN;
            end
         end
         DONE: begin
            spike_out_d = next_spk_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign w_neuron  = n_q;
   assign w_input   = i_q;
   assign spike_out = spike_out_q;

endmodule

// File: tb/tb_if_layer_scheduler.sv
// tb/tb_if_layer_scheduler.sv - directed bench with a timestep-level model of the IF layer
module tb_if_layer_scheduler;

   localparam int NI = 4;
   localparam int NN = 8;
   localparam int WS = 32;
   localparam int TH = 10;
   localparam longint SMAX = 2147483647;
   localparam longint SMIN = -SMAX - 1;
   localparam int STEP_CYCLES = NN * (NI + 1) + 1;

   logic          clk = 1'b0;
   logic          rst, start, clear;
   logic [NI-1:0] spike_in;
   logic          w_rd_en;
   logic [2:0]    w_neuron;
   logic [1:0]    w_input;
   logic [WS-1:0] w_data;
   logic          busy, done;
   logic [NN-1:0] spike_out;

   always #5 clk = ~clk;

   if_layer_scheduler dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .clear     (clear),
      .spike_in  (spike_in),
      .w_rd_en   (w_rd_en),
      .w_neuron  (w_neuron),
      .w_input   (w_input),
      .w_data    (w_data),
      .busy      (busy),
      .done      (done),
      .spike_out (spike_out)
   );

   logic [WS-1:0] wmem [NN][NI];

   always @(posedge clk)
      w_data <= w_rd_en ? wmem[w_neuron][w_input] : 32'hDEAD_BEEF;

   int errors = 0;
   int checks = 0;
   bit chk_en = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
      end
   endtask

   // Timestep model: potentials, expected spike vector, and the accepted-start cycle.
   longint        pot_m [NN];
   longint        pend_pot [NN];
   logic [NN-1:0] pend_sout;
   logic [NN-1:0] exp_sout = '0;
   bit            active = 0;
   int            cyc = 0;
   int            c0 = 0;
   int            done_rel = -1;

   function automatic longint sat(longint v);
      if (v > SMAX) return SMAX;
      if (v < SMIN) return SMIN;
      return v;
   endfunction

   task automatic model_accept(input logic [NI-1:0] spk);
      for (int n = 0; n < NN; n++) begin
         longint acc;
         acc = pot_m[n];
         for (int i = 0; i < NI; i++)
            if (spk[i]) acc = sat(acc + longint'($signed(wmem[n][i])));
`ifdef IF_LEAK_EN
         acc = sat(acc - 1);
         if (acc < 0) acc = 0;
`endif
         pend_sout[n] = (acc >= TH);
         pend_pot[n]  = (acc >= TH) ? 0 : acc;
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         active   = 0;
         exp_sout = '0;
         for (int n = 0; n < NN; n++) pot_m[n] = 0;
      end else begin
         if (!active) begin
            if (clear)
               for (int n = 0; n < NN; n++) pot_m[n] = 0;
            if (start) begin
               model_accept(spike_in);
               active = 1;
               c0     = cyc;
            end
         end else if (cyc - c0 + 1 == STEP_CYCLES + 1) begin
            exp_sout = pend_sout;
            for (int n = 0; n < NN; n++) pot_m[n] = pend_pot[n];
            active = 0;
         end
      end
   end

   always @(negedge clk) begin : cmp
      int rel, k;
      bit exp_rd;
      if (chk_en) begin
         if (active) begin
            rel    = cyc - c0 + 1;
            k      = rel - 1;
            exp_rd = (rel < STEP_CYCLES) && (k % (NI + 1) < NI);
            chk("busy", busy, 1);
            chk("done", done, rel == STEP_CYCLES);
            chk("w_rd_en", w_rd_en, exp_rd);
            if (exp_rd) begin
               chk("w_neuron", w_neuron, k / (NI + 1));
               chk("w_input", w_input, k % (NI + 1));
            end
            if (done === 1'b1) done_rel = rel;
         end else begin
            chk("busy_idle", busy, 0);
            chk("done_idle", done, 0);
            chk("w_rd_en_idle", w_rd_en, 0);
         end
         chk("spike_out", spike_out, exp_sout);
      end
   end

   task automatic set_w(input logic [WS-1:0] v);
      for (int n = 0; n < NN; n++)
         for (int i = 0; i < NI; i++) wmem[n][i] = v;
   endtask

   task automatic check_pots();
      for (int n = 0; n < NN; n++)
         chk("potential", 64'($signed(dut.u_bank.mem_q[n])), pot_m[n]);
   endtask

   // Runs one timestep; optionally asserts clear with start, or pokes start/spike_in mid-step.
   task automatic run_step(input logic [NI-1:0] spk, input bit clr, input bit poke);
      int guard;
      start    = 1'b1;
      clear    = clr;
      spike_in = spk;
      @(negedge clk);
      start = 1'b0;
      clear = 1'b0;
      guard = 0;
      while (active && guard < 200) begin
         if (poke && guard == 10) begin
            start    = 1'b1;
            spike_in = ~spk;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         guard++;
      end
      start = 1'b0;
      if (active) begin
         checks++;
         errors++;
         $display("FAIL timeout: got busy after %0d cycles expected done", guard);
      end
      check_pots();
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      clear    = 1'b0;
      spike_in = '0;
      set_w('0);
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", w_rd_en, 0);
      chk("rst_neuron", w_neuron, 0);
      chk("rst_input", w_input, 0);
      chk("rst_sout", spike_out, 0);
      rst    = 1'b0;
      chk_en = 1;
      @(negedge clk);

`ifndef IF_LEAK_EN
      set_w(32'd3);
      run_step(4'b1111, 0, 0);
      chk("all3_sout", spike_out, 8'hFF);
      chk("latency", done_rel, 41);
      chk("all3_pot7", 64'($signed(dut.u_bank.mem_q[7])), 0);

      start    = 1'b1;
      spike_in = 4'b1111;
      @(negedge clk);
      start = 1'b0;
      repeat (18) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_sout", spike_out, 0);
      repeat (45) @(negedge clk);

      run_step(4'b1111, 0, 0);
      chk("after_abort_sout", spike_out, 8'hFF);

      set_w(32'd1);
      for (int s = 1; s <= 3; s++) begin
         run_step(4'b0011, 0, 0);
         chk("integ_sout", spike_out, 0);
         chk("integ_pot0", 64'($signed(dut.u_bank.mem_q[0])), 2 * s);
      end
      run_step(4'b0000, 0, 0);
      chk("zero_in_pot2", 64'($signed(dut.u_bank.mem_q[2])), 6);
      set_w(32'd2);
      run_step(4'b1111, 0, 0);
      chk("integ_fire_sout", spike_out, 8'hFF);

      set_w(32'd1);
      run_step(4'b0011, 0, 0);
      run_step(4'b0000, 1, 0);
      chk("clear_pot3", 64'($signed(dut.u_bank.mem_q[3])), 0);

      set_w('0);
      for (int i = 0; i < NI; i++) wmem[5][i] = 32'h7FFF_FFFF;
      run_step(4'b1111, 0, 0);
      chk("sat_pos_sout", spike_out, 8'h20);
      for (int i = 0; i < NI; i++) wmem[5][i] = 32'h8000_0000;
      run_step(4'b1111, 0, 0);
      chk("sat_neg_sout", spike_out, 0);
      chk("sat_neg_pot5", 64'($signed(dut.u_bank.mem_q[5])), SMIN);

      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      set_w(32'd1);
      run_step(4'b0011, 0, 1);
      chk("poke_pot0", 64'($signed(dut.u_bank.mem_q[0])), 2);
      chk("poke_sout", spike_out, 0);
      repeat (3) @(negedge clk);
`else
      set_w(32'd1);
      for (int s = 1; s <= 5; s++) begin
         run_step(4'b0001, 0, 0);
         chk("leak_hold_sout", spike_out, 0);
         chk("leak_hold_pot0", 64'($signed(dut.u_bank.mem_q[0])), 0);
      end
      for (int s = 1; s <= 5; s++) begin
         run_step(4'b0111, 0, 0);
         chk("leak_sout", spike_out, (s == 5) ? 8'hFF : 8'h00);
         chk("leak_pot0", 64'($signed(dut.u_bank.mem_q[0])), (s == 5) ? 0 : 2 * s);
      end
`endif

      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
